instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The module SHALL have these parameters:
  - ADDR_W, 8: program counter and instruction-memory address width.
  - INSTR_W, 12: instruction width; opcode is [INSTR_W-1:INSTR_W-4], operand is [ADDR_W-1:0].
REQ-002 The module SHALL have these ports:
  - clk  in  1  single clock; all state changes on its rising edge.
  - rst  in  1  synchronous reset, active-high.
  - imem_req  out  1  instruction fetch request.
  - imem_addr  out  ADDR_W  fetch address; equals pc.
  - imem_ack  in  1  fetch data valid this cycle.
  - imem_data  in  INSTR_W  fetched instruction.
  - opcode  out  4  latched opcode, driven to the control decoder.
  - operand  out  ADDR_W  latched operand (branch vector, memory address).
  - issue_valid  out  1  one-cycle strobe; opcode and operand are valid for execution.
  - src_pc  in  2  PC source from the control decoder (00 sequential, 01 jump).
  - carry_flag  in  1  ALU carry, sampled in EXEC.
  - zero_flag  in  1  ALU zero, sampled in EXEC.
  - halt  in  1  stop request.
  - pc  out  ADDR_W  current program counter.
  - halted  out  1  high while in HALT.
  - illegal  out  1  sticky illegal-opcode flag.

Function
REQ-003 The FSM SHALL have six states: IDLE, FETCH, EXEC, UPDATE, HALT and ERROR.
REQ-004 IDLE SHALL last exactly one cycle after reset and then go to FETCH.
REQ-005 In FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_ack.
  - When imem_ack=1, imem_data is latched into opcode/operand and the FSM goes to EXEC.
  - imem_ack in the first FETCH cycle is legal.
REQ-006 imem_ack SHALL be ignored in every state except FETCH.
REQ-007 In EXEC:
  - issue_valid=1 for exactly one cycle.
  - src_pc, carry_flag and zero_flag are sampled.
  - Opcode 4'b0111 goes to ERROR; any other opcode goes to UPDATE.
REQ-008 In UPDATE, next pc SHALL be:
  - operand if src_pc==01;
  - operand if opcode==1010 (BCC) and carry==0;
  - operand if opcode==1011 (BNE) and zero==0;
  - pc+1 otherwise.
REQ-009 src_pc values 10 and 11 SHALL be treated as 00.
REQ-010 pc+1 SHALL wrap modulo 2^ADDR_W (255 -> 0).
REQ-011 UPDATE SHALL go to HALT if halt=1 in that cycle, else to FETCH.
REQ-012 halt SHALL be sampled only in UPDATE, so an instruction in flight always completes.
REQ-013 HALT:
  - halted=1 and imem_req=0;
  - the FSM stays in HALT while halt=1;
  - when halt=0, it goes to FETCH at the updated pc.
REQ-014 ERROR:
  - illegal=1, imem_req=0 and issue_valid=0;
  - exits only on rst.
REQ-015 Minimum instruction period SHALL be 3 cycles: FETCH with immediate ack, then EXEC, then UPDATE.
REQ-016 opcode and operand SHALL change only on the FETCH->EXEC transition and hold otherwise.

Reset
REQ-017 On rst=1 at a clock edge, the following SHALL be applied in any state, including mid-fetch:
  - state=IDLE and pc=0;
  - imem_req=0 and issue_valid=0;
  - opcode=0000 and operand=0;
  - halted=0 and illegal=0.
REQ-018 A pending imem_ack in the reset cycle SHALL be discarded.

Structure
REQ-019 The shared package cpu_pkg SHALL hold:
  - the state enum;
  - the opcode constants (JMP, BCC, BNE, ILLEGAL=0111);
  - the src_pc encodings;
  - the ADDR_W/INSTR_W defaults.
REQ-020 Next-pc selection SHALL be a combinational sub-module pc_next (inputs: pc, operand, opcode, src_pc, carry, zero; output: next pc).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - Reset, then fetch 0x1_05 with immediate ack and src_pc=00 -> issue_valid pulses in cycle 3, opcode=0001, operand=05, pc=1 after UPDATE.
  - JMP 0x0_A0 with src_pc=01 -> pc=0xA0; the next imem_addr is 0xA0.
  - BCC 0xA_10 with carry=0 -> pc=0x10; the same instruction with carry=1 -> pc+1.
  - BNE with zero=0 -> taken; with zero=1 -> not taken.
  - pc=0xFF with a sequential instruction -> pc=0x00.
  - Ack delayed 4 cycles -> imem_req and imem_addr held stable; no issue_valid until EXEC.
  - halt=1 during UPDATE -> halted=1 and imem_req=0.
  - Release halt -> fetch resumes at the correct pc.
  - Opcode 0111 -> illegal=1 and no further imem_req.
  - rst during a FETCH wait -> pc=0, all outputs at reset values, the late ack ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, opcode and
// PC-source encodings, and default bus widths.
package cpu_pkg;

   localparam int ADDR_W_DEF  = 8;
   localparam int INSTR_W_DEF = 12;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_UPDATE = 3'd3,
      S_HALT   = 3'd4,
      S_ERROR  = 3'd5
   } state_t;

   localparam logic [3:0] OP_JMP     = 4'b0000;
   localparam logic [3:0] OP_ILLEGAL = 4'b0111;
   localparam logic [3:0] OP_BCC     = 4'b1010;
   localparam logic [3:0] OP_BNE     = 4'b1011;

   // Only 01 redirects the pc; the two unused codes fall back to sequential.
   localparam logic [1:0] SRC_SEQ = 2'b00;
   localparam logic [1:0] SRC_JMP = 2'b01;

endpackage

// File: rtl/pc_next.sv
// Combinational next-pc selection: decoder jump, conditional branches on
// clear carry/zero, otherwise sequential with natural wrap.
module pc_next
   import cpu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] operand,
   input  logic [3:0]        opcode,
   input  logic [1:0]        src_pc,
   input  logic              carry,
   input  logic              zero,
   output logic [ADDR_W-1:0] next_pc
);

   always_comb begin
      next_pc = pc + ADDR_W'(1);
      if ((src_pc == SRC_JMP) ||
          ((opcode == OP_BCC) && !carry) ||
          ((opcode == OP_BNE) && !zero))
         next_pc = operand;
   end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute/update sequencer: fetches one instruction per pass, strobes
// it to the decoder, then advances the pc from the flags sampled in EXEC.
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [3:0]         opcode,
   output logic [ADDR_W-1:0]  operand,
   output logic               issue_valid,
   input  logic [1:0]         src_pc,
   input  logic               carry_flag,
   input  logic               zero_flag,
   input  logic               halt,
   output logic [ADDR_W-1:0]  pc,
   output logic               halted,
   output logic               illegal
);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] pc_q, pc_nx, operand_q;
   logic [3:0]        opcode_q;
   logic [1:0]        src_pc_s;
   logic              carry_s, zero_s;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   state_nx = S_FETCH;
         S_FETCH:  if (imem_ack) state_nx = S_EXEC;
         S_EXEC:   state_nx = (opcode_q == OP_ILLEGAL) ? S_ERROR : S_UPDATE;
         S_UPDATE: state_nx = halt ? S_HALT : S_FETCH;
         S_HALT:   if (!halt) state_nx = S_FETCH;
         S_ERROR:  state_nx = S_ERROR;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req    = (state == S_FETCH);
      issue_valid = (state == S_EXEC);
      halted      = (state == S_HALT);
      illegal     = (state == S_ERROR);
      imem_addr   = pc_q;
      pc          = pc_q;
      opcode      = opcode_q;
      operand     = operand_q;
   end

   // Instruction latch, EXEC-time flag capture and the pc update in UPDATE.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= '0;
         opcode_q  <= '0;
         operand_q <= '0;
         src_pc_s  <= SRC_SEQ;
         carry_s   <= 1'b0;
         zero_s    <= 1'b0;
      end else begin
         if ((state == S_FETCH) && imem_ack) begin
            opcode_q  <= imem_data[INSTR_W-1 -: 4];
            operand_q <= imem_data[ADDR_W-1:0];
         end
         if (state == S_EXEC) begin
            src_pc_s <= src_pc;
            carry_s  <= carry_flag;
            zero_s   <= zero_flag;
         end
         if (state == S_UPDATE)
            pc_q <= pc_nx;
      end
   end

   pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
      .pc      (pc_q),
      .operand (operand_q),
      .opcode  (opcode_q),
      .src_pc  (src_pc_s),
      .carry   (carry_s),
      .zero    (zero_s),
      .next_pc (pc_nx)
   );

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed plus randomized bench for instr_sequencer; expected pc values come
// from an instruction-level model of the branch rules.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [11:0] imem_data;
   logic [3:0]  opcode;
   logic [7:0]  operand;
   logic        issue_valid;
   logic [1:0]  src_pc;
   logic        carry_flag;
   logic        zero_flag;
   logic        halt;
   logic [7:0]  pc;
   logic        halted;
   logic        illegal;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  m_pc;

   always #5 clk = ~clk;

   instr_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .opcode      (opcode),
      .operand     (operand),
      .issue_valid (issue_valid),
      .src_pc      (src_pc),
      .carry_flag  (carry_flag),
      .zero_flag   (zero_flag),
      .halt        (halt),
      .pc          (pc),
      .halted      (halted),
      .illegal     (illegal)
   );

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Program-level rule: where does the pc go after this instruction retires.
   function automatic logic [7:0] model_next(input logic [7:0] cur, input logic [11:0] instr,
                                             input logic [1:0] sp, input logic c, input logic z);
      logic [3:0] op;
      op = instr[11:8];
      if (sp == 2'b01)              return instr[7:0];
      if (op == 4'hA && c == 1'b0)  return instr[7:0];
      if (op == 4'hB && z == 1'b0)  return instr[7:0];
      return cur + 8'd1;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},    imem_req,    1'b0);
      chk({tag, "_issue"},  issue_valid, 1'b0);
      chk({tag, "_opcode"}, opcode,      4'h0);
      chk({tag, "_operand"},operand,     8'h00);
      chk({tag, "_pc"},     pc,          8'h00);
      chk({tag, "_halted"}, halted,      1'b0);
      chk({tag, "_illegal"},illegal,     1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1; imem_ack = 1'b0; halt = 1'b0;
      step();
      rst = 1'b0;
      chk_reset_vals("rst");
      step();
      m_pc = 8'h00;
      chk("idle_then_fetch", imem_req, 1'b1);
   endtask

   // Entered in FETCH; leaves the DUT in FETCH, HALT or ERROR.
   task automatic run_instr(input string tag, input logic [11:0] instr, input int dly,
                            input logic [1:0] sp, input logic c, input logic z, input logic h);
      logic [7:0] exp_pc;
      chk({tag, "_req"},  imem_req,  1'b1);
      chk({tag, "_addr"}, imem_addr, m_pc);
      for (int d = 0; d < dly; d++) begin
         imem_ack  = 1'b0;
         imem_data = 12'($urandom);
         halt      = 1'($urandom);
         step();
         chk({tag, "_wait_req"},   imem_req,    1'b1);
         chk({tag, "_wait_addr"},  imem_addr,   m_pc);
         chk({tag, "_wait_issue"}, issue_valid, 1'b0);
      end
      imem_ack  = 1'b1;
      imem_data = instr;
      halt      = 1'($urandom);
      step();
      // EXEC: a stray ack with other data must not disturb the latch.
      imem_ack   = 1'b1;
      imem_data  = ~instr;
      src_pc     = sp;
      carry_flag = c;
      zero_flag  = z;
      chk({tag, "_issue"},   issue_valid, 1'b1);
      chk({tag, "_opcode"},  opcode,      instr[11:8]);
      chk({tag, "_operand"}, operand,     instr[7:0]);
      chk({tag, "_exec_req"},imem_req,    1'b0);
      step();
      imem_ack = 1'b0;
      if (instr[11:8] == 4'h7) begin
         chk({tag, "_illegal"}, illegal,     1'b1);
         chk({tag, "_err_req"}, imem_req,    1'b0);
         chk({tag, "_err_iss"}, issue_valid, 1'b0);
         return;
      end
      // UPDATE: flags now change, but the EXEC samples must be used.
      chk({tag, "_upd_issue"}, issue_valid, 1'b0);
      chk({tag, "_hold_op"},   opcode,      instr[11:8]);
      src_pc     = 2'($urandom);
      carry_flag = 1'($urandom);
      zero_flag  = 1'($urandom);
      halt       = h;
      exp_pc = model_next(m_pc, instr, sp, c, z);
      step();
      halt = h;
      m_pc = exp_pc;
      chk({tag, "_pc"}, pc, m_pc);
      if (h) begin
         chk({tag, "_halted"},   halted,   1'b1);
         chk({tag, "_halt_req"}, imem_req, 1'b0);
      end else begin
         chk({tag, "_next_req"},  imem_req,  1'b1);
         chk({tag, "_next_addr"}, imem_addr, m_pc);
      end
   endtask

   task automatic release_halt(input string tag, input int hold);
      for (int i = 0; i < hold; i++) begin
         halt     = 1'b1;
         imem_ack = 1'($urandom);
         step();
         chk({tag, "_stay"},     halted,   1'b1);
         chk({tag, "_stay_req"}, imem_req, 1'b0);
      end
      halt = 1'b0; imem_ack = 1'b0;
      step();
      chk({tag, "_halted"}, halted,    1'b0);
      chk({tag, "_req"},    imem_req,  1'b1);
      chk({tag, "_addr"},   imem_addr, m_pc);
   endtask

   initial begin
      logic [11:0] ins;
      logic [3:0]  op;
      rst = 1'b1; imem_ack = 1'b0; imem_data = 12'h000; src_pc = 2'b00;
      carry_flag = 1'b0; zero_flag = 1'b0; halt = 1'b0;
      step();
      do_reset();

      run_instr("seq",     12'h105, 0, 2'b00, 1'b1, 1'b1, 1'b0);
      chk("seq_pc1", pc, 8'h01);
      run_instr("jmp",     12'h0A0, 0, 2'b01, 1'b1, 1'b1, 1'b0);
      chk("jmp_pcA0", pc, 8'hA0);
      run_instr("bcc_tk",  12'hA10, 0, 2'b00, 1'b0, 1'b1, 1'b0);
      chk("bcc_pc10", pc, 8'h10);
      run_instr("bcc_nt",  12'hA10, 1, 2'b00, 1'b1, 1'b0, 1'b0);
      chk("bcc_pc11", pc, 8'h11);
      run_instr("bne_tk",  12'hB40, 0, 2'b00, 1'b1, 1'b0, 1'b0);
      run_instr("bne_nt",  12'hB80, 0, 2'b00, 1'b0, 1'b1, 1'b0);
      run_instr("src10",   12'h322, 0, 2'b10, 1'b1, 1'b1, 1'b0);
      run_instr("src11",   12'h333, 0, 2'b11, 1'b1, 1'b1, 1'b0);
      run_instr("jmp_ff",  12'h0FF, 0, 2'b01, 1'b1, 1'b1, 1'b0);
      run_instr("wrap",    12'h200, 0, 2'b00, 1'b1, 1'b1, 1'b0);
      chk("wrap_pc0", pc, 8'h00);
      run_instr("slow",    12'h4C3, 4, 2'b00, 1'b1, 1'b1, 1'b0);
      run_instr("halt",    12'h155, 0, 2'b00, 1'b1, 1'b1, 1'b1);
      release_halt("rel", 3);

      for (int n = 0; n < 30; n++) begin
         do begin
            ins = 12'($urandom);
            op  = ins[11:8];
         end while (op == 4'h7);
         run_instr("rnd", ins, int'($urandom_range(0, 3)), 2'($urandom),
                   1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
         if (halted) release_halt("rnd_rel", int'($urandom_range(0, 2)));
      end

      // Reset while a fetch is waiting, with a late ack in the reset cycle.
      imem_ack = 1'b0;
      step();
      step();
      chk("rstf_waiting", imem_req, 1'b1);
      rst = 1'b1; imem_ack = 1'b1; imem_data = 12'h533;
      step();
      rst = 1'b0; imem_ack = 1'b0;
      chk_reset_vals("rstf");
      step();
      m_pc = 8'h00;
      chk("rstf_op_kept0", opcode, 4'h0);
      run_instr("after_rst", 12'h1AB, 0, 2'b00, 1'b1, 1'b1, 1'b0);

      run_instr("illegal", 12'h712, 1, 2'b01, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         imem_ack = 1'($urandom);
         halt     = 1'($urandom);
         step();
         chk("err_stuck", illegal, 1'b1);
         chk("err_noreq", imem_req, 1'b0);
      end
      do_reset();
      chk("err_cleared", illegal, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
